gate_truth_checker: RTL and testbench

//  Self-checking stimulus/response stage for N-input combinational gates (and_gate, or_gate, ...).

---
 rtl/gate_chk_pkg.sv | 17 +
 rtl/gate_chk_if.sv | 34 +++
 rtl/and_gate.sv | 10 +
 rtl/gate_chk_settle_timer.sv | 27 ++
 rtl/gate_truth_checker.sv | 143 ++++++++++++++
 tb/tb_gate_truth_checker.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - shared FSM encoding and vector-count helper for gate_truth_checker
package gate_chk_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_chk_state_t;

  function automatic int vec_count(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_chk_if.sv
// rtl/gate_chk_if.sv - stimulus/response bundle between checker and gate under test (GATE_CHK_CAPTURE_EN adds obs_table)
interface gate_chk_if #(
  parameter int N_IN = 2
);
  logic                  start;
  logic [N_IN-1:0]       vec;
  logic                  y;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [N_IN:0]         err_count;
  logic [N_IN-1:0]       first_fail;
`ifdef GATE_CHK_CAPTURE_EN
  logic [(1<<N_IN)-1:0]  obs_table;

  modport master (
    input  start, y,
    output vec, busy, done, pass, err_count, first_fail, obs_table
  );
  modport slave (
    output start, y,
    input  vec, busy, done, pass, err_count, first_fail, obs_table
  );
`else
  modport master (
    input  start, y,
    output vec, busy, done, pass, err_count, first_fail
  );
  modport slave (
    output start, y,
    input  vec, busy, done, pass, err_count, first_fail
  );
`endif
endinterface

// File: rtl/and_gate.sv
// rtl/and_gate.sv - two-input AND gate used as the reference gate under test
module and_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a & b;

endmodule

// File: rtl/gate_chk_settle_timer.sv
// rtl/gate_chk_settle_timer.sv - loadable down-counter with zero flag for the settle interval
module gate_chk_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - sweeps all input vectors of a gate and scores y against TRUTH
// Optional GATE_CHK_CAPTURE_EN records every sampled y into obs_table.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int                    N_IN       = 2,
  parameter logic [2**N_IN-1:0]    TRUTH      = 4'b1000,
  parameter int                    SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  gate_chk_if.master bus
);

  localparam int N_VEC = vec_count(N_IN);
  localparam int TW    = $clog2(SETTLE_CYC) + 1;

  gate_chk_state_t   state, state_nxt;
  logic [N_IN-1:0]   idx;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail;
  logic              pass;

  logic              timer_load;
  logic              timer_dec;
  logic              timer_zero;

  logic              accept;
  logic              sample_fire;
  logic              last_vec;
  logic              exp_bit;
  logic              mismatch;

  gate_chk_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TW'(SETTLE_CYC - 1)),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_nxt = SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept      = (state == IDLE) && bus.start;
  assign sample_fire = (state == SAMPLE);
  assign last_vec    = (idx == N_IN'(N_VEC - 1));
  assign exp_bit     = TRUTH[idx];
  // Four-state compare so an undriven or X output from the gate scores as a failure.
  assign mismatch    = (bus.y !== exp_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      idx        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (sample_fire) begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_fail <= idx;
        end
      end
      // pass must reflect this final compare too, since err_count updates on the same edge.
      if (last_vec) begin
        pass <= !mismatch && (err_count == '0);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef GATE_CHK_CAPTURE_EN
  logic [N_VEC-1:0] obs_table;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_table <= '0;
    end else if (accept) begin
      obs_table <= '0;
    end else if (sample_fire) begin
      obs_table[idx] <= bus.y;
    end
  end

  assign bus.obs_table = obs_table;
`endif

  assign bus.vec        = idx;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.pass       = pass;
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - randomized self-checking bench for gate_truth_checker against and_gate
module tb_gate_truth_checker;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_r;
  int         tests_run;
  int         tests_failed;

  gate_chk_if #(.N_IN(2)) if_a ();
  gate_chk_if #(.N_IN(2)) if_b ();
  gate_chk_if #(.N_IN(2)) if_c ();

  assign if_a.start = start_r[0];
  assign if_b.start = start_r[1];
  assign if_c.start = start_r[2];

  and_gate g_a (.a(if_a.vec[0]), .b(if_a.vec[1]), .y(if_a.y));
  and_gate g_b (.a(if_b.vec[0]), .b(if_b.vec[1]), .y(if_b.y));
  and_gate g_c (.a(if_c.vec[0]), .b(if_c.vec[1]), .y(if_c.y));

  gate_truth_checker dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  gate_truth_checker #(.TRUTH(4'b1110)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  gate_truth_checker #(.SETTLE_CYC(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [1:0] o_vec   [3];
  logic       o_busy  [3];
  logic       o_done  [3];
  logic       o_pass  [3];
  logic [2:0] o_err   [3];
  logic [1:0] o_ff    [3];

  assign o_vec[0] = if_a.vec;        assign o_vec[1] = if_b.vec;        assign o_vec[2] = if_c.vec;
  assign o_busy[0] = if_a.busy;      assign o_busy[1] = if_b.busy;      assign o_busy[2] = if_c.busy;
  assign o_done[0] = if_a.done;      assign o_done[1] = if_b.done;      assign o_done[2] = if_c.done;
  assign o_pass[0] = if_a.pass;      assign o_pass[1] = if_b.pass;      assign o_pass[2] = if_c.pass;
  assign o_err[0] = if_a.err_count;  assign o_err[1] = if_b.err_count;  assign o_err[2] = if_c.err_count;
  assign o_ff[0] = if_a.first_fail;  assign o_ff[1] = if_b.first_fail;  assign o_ff[2] = if_c.first_fail;

`ifdef GATE_CHK_CAPTURE_EN
  logic [3:0] o_obs [3];
  assign o_obs[0] = if_a.obs_table;  assign o_obs[1] = if_b.obs_table;  assign o_obs[2] = if_c.obs_table;
`endif

  logic [3:0] truth_of  [3];
  int         settle_of [3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the gate is AND, so y is 1 only for vector 3.
  function automatic void model(input logic [3:0] t, output int err, output int ff, output logic [3:0] obs);
    err = 0;
    ff  = 0;
    obs = '0;
    for (int v = 0; v < 4; v++) begin
      obs[v] = (v == 3);
      if (obs[v] != t[v]) begin
        if (err == 0) ff = v;
        err++;
      end
    end
  endfunction

  // mode 0: clean, 1: random start noise while busy, 2: start at cycle 4 and in DONE
  task automatic run_sweep(input int w, input int mode);
    int s, len, e_err, e_ff, e_vec;
    logic [3:0] e_obs;
    logic e_pass;
    s = settle_of[w];
    len = 4 * (s + 1);
    model(truth_of[w], e_err, e_ff, e_obs);
    e_pass = (e_err == 0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    start_r[w] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= len + 1; k++) begin
      @(negedge clk);
      e_vec = (k < len) ? k / (s + 1) : 3;
      tests_run++;
      if (o_vec[w] !== 2'(e_vec)) begin
        tests_failed++;
        $display("FAIL vec dut%0d cycle %0d got %0d exp %0d", w, k, o_vec[w], e_vec);
      end
      tests_run++;
      if (o_busy[w] !== (k <= len)) begin
        tests_failed++;
        $display("FAIL busy dut%0d cycle %0d got %0b exp %0b", w, k, o_busy[w], (k <= len));
      end
      tests_run++;
      if (o_done[w] !== (k == len)) begin
        tests_failed++;
        $display("FAIL done dut%0d cycle %0d got %0b exp %0b", w, k, o_done[w], (k == len));
      end
      if (k < len) begin
        tests_run++;
        if (o_pass[w] !== 1'b0) begin
          tests_failed++;
          $display("FAIL pass_cleared dut%0d cycle %0d got %0b exp 0", w, k, o_pass[w]);
        end
      end else begin
        tests_run++;
        if (o_pass[w] !== e_pass || o_err[w] !== 3'(e_err) || o_ff[w] !== 2'(e_ff)) begin
          tests_failed++;
          $display("FAIL result dut%0d cycle %0d got pass=%0b err=%0d ff=%0d exp pass=%0b err=%0d ff=%0d",
                   w, k, o_pass[w], o_err[w], o_ff[w], e_pass, e_err, e_ff);
        end
      end
`ifdef GATE_CHK_CAPTURE_EN
      if (k == 0 || k == len) begin
        tests_run++;
        if (o_obs[w] !== ((k == 0) ? 4'b0000 : e_obs)) begin
          tests_failed++;
          $display("FAIL obs_table dut%0d cycle %0d got %b exp %b", w, k, o_obs[w], (k == 0) ? 4'b0000 : e_obs);
        end
      end
`endif
      case (mode)
        1:       start_r[w] = (k <= len) && ($urandom_range(0, 3) == 0);
        2:       start_r[w] = (k == 4) || (k == len);
        default: start_r[w] = 1'b0;
      endcase
    end
    start_r[w] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start_r = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      tests_run++;
      if (o_vec[w] !== 0 || o_busy[w] !== 0 || o_done[w] !== 0 || o_pass[w] !== 0 || o_err[w] !== 0 || o_ff[w] !== 0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d exp all 0",
                 w, o_vec[w], o_busy[w], o_done[w], o_pass[w], o_err[w], o_ff[w]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_sweep;
    bit saw_done;
    run_sweep(1, 0);
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (o_vec[0] !== 2'd1) begin
      tests_failed++;
      $display("FAIL pre_reset_vec got %0d exp 1", o_vec[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_vec[0] !== 0 || o_busy[0] !== 0 || o_done[0] !== 0 || o_pass[0] !== 0 || o_err[0] !== 0 || o_ff[0] !== 0) begin
      tests_failed++;
      $display("FAIL async_reset dut0 got vec=%0d busy=%0b done=%0b pass=%0b err=%0d ff=%0d exp all 0",
               o_vec[0], o_busy[0], o_done[0], o_pass[0], o_err[0], o_ff[0]);
    end
    tests_run++;
    if (o_err[1] !== 0 || o_ff[1] !== 0) begin
      tests_failed++;
      $display("FAIL async_reset dut1 got err=%0d ff=%0d exp 0 0", o_err[1], o_ff[1]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_done[0] || o_busy[0]) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_done_after_reset got activity=%0b exp 0", saw_done);
    end
    run_sweep(0, 0);
  endtask

  task automatic test_back_to_back;
    int dq[$];
    int len;
    len = 4 * (settle_of[0] + 1);
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 2 * len + 4; c++) begin
      @(negedge clk);
      if (c == len + 2) start_r[0] = 1'b0;
      if (o_done[0] === 1'b1) dq.push_back(c);
    end
    tests_run++;
    if (dq.size() != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count got %0d exp 2", dq.size());
    end else begin
      tests_run++;
      if (dq[0] != len || dq[1] != 2 * len + 2) begin
        tests_failed++;
        $display("FAIL b2b_done_cycles got %0d,%0d exp %0d,%0d", dq[0], dq[1], len, 2 * len + 2);
      end
    end
    tests_run++;
    if (o_pass[0] !== 1'b1 || o_err[0] !== 0) begin
      tests_failed++;
      $display("FAIL b2b_result got pass=%0b err=%0d exp pass=1 err=0", o_pass[0], o_err[0]);
    end
  endtask

  task automatic test_random_sweeps;
    for (int i = 0; i < 12; i++) begin
      run_sweep($urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    truth_of[0]  = 4'b1000;  settle_of[0] = 1;
    truth_of[1]  = 4'b1110;  settle_of[1] = 1;
    truth_of[2]  = 4'b1000;  settle_of[2] = 3;
    test_reset();
    run_sweep(0, 0);
    run_sweep(1, 0);
    run_sweep(2, 0);
    run_sweep(0, 2);
    test_reset_mid_sweep();
    test_back_to_back();
    test_random_sweeps();
    run_sweep(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
